// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared scoreboard entry type, forwarding constants and priority helper
package hazard_pkg;

  // Entry rd is stored at a fixed width so the type can live in the package
  localparam int SB_RD_W         = 8;
  localparam int FWD_SEL_REGFILE = 0;

  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
    logic               reg_write;
    logic               mem_read;
  } sb_entry_t;

  function automatic int youngest_match(input logic [31:0] hits);
    int y;
    y = -1;
    for (int j = 31; j >= 0; j--) begin
      if (hits[j]) y = j;
    end
    return y;
  endfunction

endpackage

// File: rtl/hazard_src_match.sv
// rtl/hazard_src_match.sv - per-operand youngest-producer search and load-usability check
module hazard_src_match
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int FWD_DEPTH  = 3,
  parameter int LOAD_LAT   = 1,
  parameter int FWD_SEL_W  = 2
) (
  input  logic [REG_ADDR_W-1:0]     rs,
  input  logic                      rs_used,
  input  sb_entry_t [FWD_DEPTH-1:0] ent,
  output logic                      hazard,
  output logic [FWD_SEL_W-1:0]      sel
);

  logic [FWD_DEPTH-1:0] hits;
  logic [FWD_DEPTH-1:0] unusable;
  int                   y;

  always_comb begin
    hits     = '0;
    unusable = '0;
    for (int j = 0; j < FWD_DEPTH; j++) begin
      hits[j] = rs_used && (rs != '0) && ent[j].valid && ent[j].reg_write &&
                (ent[j].rd == SB_RD_W'(rs));
      unusable[j] = ent[j].mem_read && (j < LOAD_LAT);
    end

    y      = youngest_match(32'(hits));
    hazard = 1'b0;
    sel    = FWD_SEL_W'(FWD_SEL_REGFILE);
    // The oldest stage is covered by regfile write-before-read, so it keeps sel = 0
    for (int j = 0; j < FWD_DEPTH; j++) begin
      if (j == y) begin
        hazard = unusable[j];
        if (j < FWD_DEPTH - 1) sel = FWD_SEL_W'(j + 1);
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_scoreboard.sv
// rtl/pipeline_hazard_scoreboard.sv - in-flight rd scoreboard, load-use stall, EX-aligned forwarding selects
// Optional saturating perf counters enabled by HAZARD_PERF_CNT_EN.
module pipeline_hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int FWD_DEPTH  = 3,
  parameter int LOAD_LAT   = 1,
  localparam int FWD_SEL_W = $clog2(FWD_DEPTH)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0]   id_rs,
  input  logic [NUM_SRC-1:0]              id_rs_used,
  input  logic [REG_ADDR_W-1:0]           id_rd,
  input  logic                            id_reg_write,
  input  logic                            id_mem_read,
  input  logic                            flush,
  output logic                            stall,
  output logic [NUM_SRC*FWD_SEL_W-1:0]    ex_fwd_sel,
  output logic [31:0]                     perf_stall_cnt,
  output logic [31:0]                     perf_flush_cnt
);

  sb_entry_t [FWD_DEPTH-1:0]      ent;
  logic [NUM_SRC-1:0]             src_hazard;
  logic [NUM_SRC*FWD_SEL_W-1:0]   sel_next;
  logic                           issue;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    hazard_src_match #(
      .REG_ADDR_W (REG_ADDR_W),
      .FWD_DEPTH  (FWD_DEPTH),
      .LOAD_LAT   (LOAD_LAT),
      .FWD_SEL_W  (FWD_SEL_W)
    ) u_match (
      .rs      (id_rs[g*REG_ADDR_W +: REG_ADDR_W]),
      .rs_used (id_rs_used[g]),
      .ent     (ent),
      .hazard  (src_hazard[g]),
      .sel     (sel_next[g*FWD_SEL_W +: FWD_SEL_W])
    );
  end

  // Gating with reset makes a stall collapse in the same cycle reset asserts
  assign stall = reset & id_valid & ~flush & (|src_hazard);
  assign issue = id_valid & ~stall & ~flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent        <= '0;
      ex_fwd_sel <= '0;
    end else begin
      for (int i = 1; i < FWD_DEPTH; i++) begin
        ent[i] <= ent[i-1];
      end
      if (issue) begin
        ent[0].valid     <= 1'b1;
        ent[0].rd        <= SB_RD_W'(id_rd);
        ent[0].reg_write <= id_reg_write;
        ent[0].mem_read  <= id_mem_read;
        ex_fwd_sel       <= sel_next;
      end else begin
        ent[0]     <= '0;
        ex_fwd_sel <= '0;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush && id_valid && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_flush_cnt = 32'd0;
`endif

endmodule
